// File: rtl/reg_bus_arb.sv
// Register-bus arbiter: port A (unstallable pulses) vs port B (req/ack with lock).
// A accesses arriving under a B lock are held in a FIFO and drained in order.
module reg_bus_arb #(
   parameter int FIFO_DEPTH = 2,
   parameter int LOCK_MAX   = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_read,
   input  logic       a_write,
   input  logic [5:0] a_addr,
   input  logic [7:0] a_wdata,
   output logic [7:0] a_rdata,
   output logic       a_rvalid,
   output logic       a_ovf,
   input  logic       a_ovf_clr,
   input  logic       b_req,
   input  logic       b_we,
   input  logic       b_lock,
   input  logic [5:0] b_addr,
   input  logic [7:0] b_wdata,
   output logic [7:0] b_rdata,
   output logic       b_ack,
   output logic       lock_to,
   output logic       reg_read,
   output logic       reg_write,
   output logic [5:0] reg_addr,
   output logic [7:0] reg_wdata,
   input  logic [7:0] reg_rdata
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int LW = $clog2(LOCK_MAX + 1);

   typedef struct packed {
      logic       we;
      logic [5:0] addr;
      logic [7:0] wdata;
   } acc_t;

   typedef enum logic [1:0] {S_IDLE, S_LOCKED, S_DRAIN} state_t;

   state_t        r_state, w_nstate;
   acc_t          r_fifo [FIFO_DEPTH];
   logic [PW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_cnt;
   logic [LW-1:0] r_lock_cnt, w_lock_cnt_nxt;
   logic          r_stb_a_rd, r_stb_b, r_stb_b_rd;

   acc_t w_a_acc, w_b_acc, w_iss;
   logic w_a_pulse, w_b_ok, w_full;
   logic w_issue, w_iss_b, w_push, w_pop, w_ovf_set, w_lock_clr, w_lock_to, w_leave;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_a_pulse      = a_read | a_write;
   assign w_a_acc        = '{we: a_write, addr: a_addr, wdata: a_wdata};
   assign w_b_acc        = '{we: b_we, addr: b_addr, wdata: b_wdata};
   // B is only sampled when nothing of its own is on the bus or being acked
   assign w_b_ok         = b_req & ~r_stb_b & ~b_ack;
   assign w_full         = (r_cnt == CW'(FIFO_DEPTH));
   assign w_lock_cnt_nxt = r_lock_cnt + 1'b1;

   always_comb begin
      w_nstate   = r_state;
      w_issue    = 1'b0;
      w_iss_b    = 1'b0;
      w_iss      = w_a_acc;
      w_push     = 1'b0;
      w_pop      = 1'b0;
      w_ovf_set  = 1'b0;
      w_lock_clr = 1'b0;
      w_lock_to  = 1'b0;
      w_leave    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_a_pulse) begin
               w_issue = 1'b1;
            end else if (w_b_ok) begin
               w_issue = 1'b1;
               w_iss_b = 1'b1;
               w_iss   = w_b_acc;
               if (b_lock) begin
                  w_nstate   = S_LOCKED;
                  w_lock_clr = 1'b1;
               end
            end
         end
         S_LOCKED: begin
            if (w_a_pulse) begin
               if (w_full) w_ovf_set = 1'b1;
               else        w_push    = 1'b1;
            end
            if (w_b_ok) begin
               w_issue = 1'b1;
               w_iss_b = 1'b1;
               w_iss   = w_b_acc;
               if (!b_lock) w_leave = 1'b1;
            end
            if (w_lock_cnt_nxt == LW'(LOCK_MAX)) begin
               w_leave   = 1'b1;
               w_lock_to = 1'b1;
            end
            if (w_leave) w_nstate = ((r_cnt != '0) || w_push) ? S_DRAIN : S_IDLE;
         end
         S_DRAIN: begin
            // pop always frees a slot, so a same-cycle push can never overflow
            w_pop   = 1'b1;
            w_issue = 1'b1;
            w_iss   = r_fifo[r_rptr];
            w_push  = w_a_pulse;
            if ((r_cnt == CW'(1)) && !w_a_pulse) w_nstate = S_IDLE;
         end
         default: w_nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_wptr] <= w_a_acc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_cnt      <= '0;
         r_lock_cnt <= '0;
         r_stb_a_rd <= 1'b0;
         r_stb_b    <= 1'b0;
         r_stb_b_rd <= 1'b0;
         reg_read   <= 1'b0;
         reg_write  <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         a_rdata    <= '0;
         a_rvalid   <= 1'b0;
         a_ovf      <= 1'b0;
         b_rdata    <= '0;
         b_ack      <= 1'b0;
         lock_to    <= 1'b0;
      end else begin
         r_state <= w_nstate;
         if (w_push) r_wptr <= f_inc(r_wptr);
         if (w_pop)  r_rptr <= f_inc(r_rptr);
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
         if (w_lock_clr)               r_lock_cnt <= '0;
         else if (r_state == S_LOCKED) r_lock_cnt <= w_lock_cnt_nxt;

         reg_read  <= w_issue & ~w_iss.we;
         reg_write <= w_issue & w_iss.we;
         if (w_issue) begin
            reg_addr  <= w_iss.addr;
            reg_wdata <= w_iss.wdata;
         end
         r_stb_a_rd <= w_issue & ~w_iss_b & ~w_iss.we;
         r_stb_b    <= w_issue & w_iss_b;
         r_stb_b_rd <= w_issue & w_iss_b & ~w_iss.we;

         a_rvalid <= r_stb_a_rd;
         if (r_stb_a_rd) a_rdata <= reg_rdata;
         b_ack <= r_stb_b;
         if (r_stb_b_rd) b_rdata <= reg_rdata;

         a_ovf   <= w_ovf_set | (a_ovf & ~a_ovf_clr);
         lock_to <= w_lock_to;
      end
   end
endmodule

// File: tb/tb_reg_bus_arb.sv
// Directed bench for reg_bus_arb: queue-based behavioural model checked every cycle,
// plus literal expectations for the hand-worked scenarios.
module tb_reg_bus_arb;
   localparam int FD = 2;
   localparam int LM = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_read, a_write, a_ovf_clr;
   logic [5:0] a_addr;
   logic [7:0] a_wdata;
   logic [7:0] a_rdata;
   logic       a_rvalid, a_ovf;
   logic       b_req, b_we, b_lock;
   logic [5:0] b_addr;
   logic [7:0] b_wdata;
   logic [7:0] b_rdata;
   logic       b_ack, lock_to;
   logic       reg_read, reg_write;
   logic [5:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;

   always #5 clk = ~clk;

   reg_bus_arb #(.FIFO_DEPTH(FD), .LOCK_MAX(LM)) dut (
      .clk(clk), .rst(rst),
      .a_read(a_read), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rdata(a_rdata), .a_rvalid(a_rvalid), .a_ovf(a_ovf), .a_ovf_clr(a_ovf_clr),
      .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rdata(b_rdata), .b_ack(b_ack), .lock_to(lock_to),
      .reg_read(reg_read), .reg_write(reg_write), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
   );

   // register file: each address returns a fixed pattern (addr 0x05 -> 0x3C)
   function automatic logic [7:0] rd_of(input logic [5:0] a);
      return {2'b00, a} ^ 8'h39;
   endfunction
   assign reg_rdata = rd_of(reg_addr);

   int checks = 0, failures = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic       we;
      logic [5:0] addr;
      logic [7:0] wdata;
      bit         is_b;
   } m_acc_t;

   m_acc_t aq[$];
   m_acc_t prev, cur, na, nb;
   bit     prev_v, iss, leave, ovf_hit, b_take;
   int     mode, lock_age, b_next_ok, mcyc = 0;
   logic   e_reg_read, e_reg_write, e_a_rvalid, e_b_ack, e_lock_to, e_a_ovf;
   logic [5:0] e_reg_addr;
   logic [7:0] e_reg_wdata, e_a_rdata, e_b_rdata;

   always @(posedge clk) begin
      mcyc++;
      if (rst) begin
         aq.delete();
         mode = 0; lock_age = 0; b_next_ok = 0; prev_v = 0;
         e_reg_read = 0; e_reg_write = 0; e_reg_addr = 0; e_reg_wdata = 0;
         e_a_rvalid = 0; e_a_rdata = 0; e_b_ack = 0; e_b_rdata = 0;
         e_lock_to = 0; e_a_ovf = 0;
      end else begin
         e_a_rvalid = prev_v && !prev.is_b && !prev.we;
         if (e_a_rvalid) e_a_rdata = rd_of(prev.addr);
         e_b_ack = prev_v && prev.is_b;
         if (e_b_ack && !prev.we) e_b_rdata = rd_of(prev.addr);
         e_lock_to = 0; ovf_hit = 0; iss = 0; leave = 0;
         na = '{we: a_write, addr: a_addr, wdata: a_wdata, is_b: 1'b0};
         nb = '{we: b_we, addr: b_addr, wdata: b_wdata, is_b: 1'b1};
         b_take = b_req && (mcyc >= b_next_ok);
         cur = na;
         case (mode)
            0: begin
               if (a_read || a_write) iss = 1;
               else if (b_take) begin
                  cur = nb; iss = 1; b_next_ok = mcyc + 3;
                  if (b_lock) begin mode = 1; lock_age = 0; end
               end
            end
            1: begin
               lock_age++;
               if (a_read || a_write) begin
                  if (aq.size() < FD) aq.push_back(na);
                  else ovf_hit = 1;
               end
               if (b_take) begin
                  cur = nb; iss = 1; b_next_ok = mcyc + 3;
                  if (!b_lock) leave = 1;
               end
               if (lock_age == LM) begin leave = 1; e_lock_to = 1; end
               if (leave) mode = (aq.size() != 0) ? 2 : 0;
            end
            default: begin
               cur = aq.pop_front(); iss = 1;
               if (a_read || a_write) aq.push_back(na);
               if (aq.size() == 0) mode = 0;
            end
         endcase
         e_a_ovf = ovf_hit ? 1'b1 : (a_ovf_clr ? 1'b0 : e_a_ovf);
         prev_v = iss; prev = cur;
         e_reg_read  = iss && !cur.we;
         e_reg_write = iss && cur.we;
         e_reg_addr  = cur.addr;
         e_reg_wdata = cur.wdata;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_reg_read", reg_read, e_reg_read);
         chk("m_reg_write", reg_write, e_reg_write);
         if (e_reg_read || e_reg_write) chk("m_reg_addr", reg_addr, e_reg_addr);
         if (e_reg_write) chk("m_reg_wdata", reg_wdata, e_reg_wdata);
         chk("m_a_rvalid", a_rvalid, e_a_rvalid);
         chk("m_a_rdata", a_rdata, e_a_rdata);
         chk("m_b_ack", b_ack, e_b_ack);
         chk("m_b_rdata", b_rdata, e_b_rdata);
         chk("m_lock_to", lock_to, e_lock_to);
         chk("m_a_ovf", a_ovf, e_a_ovf);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic clr_in();
      a_read = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_ovf_clr = 0;
      b_req = 0; b_we = 0; b_lock = 0; b_addr = 0; b_wdata = 0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_reg_read"}, reg_read, 0);
      chk({tag, "_reg_write"}, reg_write, 0);
      chk({tag, "_reg_addr"}, reg_addr, 0);
      chk({tag, "_reg_wdata"}, reg_wdata, 0);
      chk({tag, "_a_rdata"}, a_rdata, 0);
      chk({tag, "_a_rvalid"}, a_rvalid, 0);
      chk({tag, "_a_ovf"}, a_ovf, 0);
      chk({tag, "_b_rdata"}, b_rdata, 0);
      chk({tag, "_b_ack"}, b_ack, 0);
      chk({tag, "_lock_to"}, lock_to, 0);
   endtask

   initial begin
      clr_in();
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      chk_en = 1;
      chk_all_zero("rst0");
      rst = 0;
      step(2);

      // single A read of 0x05
      a_read = 1; a_addr = 6'h05;
      step(1); a_read = 0;
      chk("t1_reg_read", reg_read, 1);
      chk("t1_reg_addr", reg_addr, 6'h05);
      chk("t1_rvalid_early", a_rvalid, 0);
      step(1);
      chk("t1_rvalid", a_rvalid, 1);
      chk("t1_rdata", a_rdata, 8'h3C);
      step(2);

      // A write and B read collide: A first
      a_write = 1; a_addr = 6'h12; a_wdata = 8'hA5;
      b_req = 1; b_we = 0; b_lock = 0; b_addr = 6'h07;
      step(1); a_write = 0;
      chk("t2_a_write", reg_write, 1);
      chk("t2_a_addr", reg_addr, 6'h12);
      chk("t2_a_wdata", reg_wdata, 8'hA5);
      step(1);
      chk("t2_b_read", reg_read, 1);
      chk("t2_b_addr", reg_addr, 6'h07);
      chk("t2_b_ack_early", b_ack, 0);
      step(1);
      chk("t2_b_ack", b_ack, 1);
      chk("t2_b_rdata", b_rdata, 8'h3E);
      b_req = 0;
      step(2);

      // B held high: accesses spaced by 3 cycles
      b_req = 1; b_we = 1; b_lock = 0; b_addr = 6'h2A; b_wdata = 8'h11;
      step(9); b_req = 0;
      step(3);

      // lock 0x10, A read 0x02 queued, unlock 0x11, then drain
      b_req = 1; b_we = 1; b_lock = 1; b_addr = 6'h10; b_wdata = 8'h55;
      step(1);
      chk("t3_b0_write", reg_write, 1);
      chk("t3_b0_addr", reg_addr, 6'h10);
      a_read = 1; a_addr = 6'h02;
      step(1); a_read = 0;
      chk("t3_b0_ack", b_ack, 1);
      b_lock = 0; b_addr = 6'h11; b_wdata = 8'h66;
      step(1);
      chk("t3_a_held", reg_read, 0);
      step(1);
      chk("t3_b1_write", reg_write, 1);
      chk("t3_b1_addr", reg_addr, 6'h11);
      step(1);
      chk("t3_a_read", reg_read, 1);
      chk("t3_a_addr", reg_addr, 6'h02);
      chk("t3_b1_ack", b_ack, 1);
      b_req = 0;
      step(1);
      chk("t3_rvalid", a_rvalid, 1);
      chk("t3_rdata", a_rdata, 8'h3B);
      step(2);

      // overflow: three A writes under lock, set and clear together
      b_req = 1; b_we = 1; b_lock = 1; b_addr = 6'h20; b_wdata = 8'h77;
      step(1);
      a_write = 1; a_addr = 6'h30; a_wdata = 8'hC0;
      step(1);
      a_addr = 6'h31; a_wdata = 8'hC1;
      b_lock = 0; b_addr = 6'h21; b_wdata = 8'h78;
      step(1);
      a_addr = 6'h32; a_wdata = 8'hC2; a_ovf_clr = 1;
      step(1); a_write = 0; a_ovf_clr = 0;
      chk("t4_ovf_set", a_ovf, 1);
      chk("t4_b_addr", reg_addr, 6'h21);
      step(1);
      chk("t4_q0_write", reg_write, 1);
      chk("t4_q0_addr", reg_addr, 6'h30);
      chk("t4_q0_wdata", reg_wdata, 8'hC0);
      b_req = 0;
      step(1);
      chk("t4_q1_addr", reg_addr, 6'h31);
      chk("t4_q1_wdata", reg_wdata, 8'hC1);
      step(1);
      chk("t4_no_third", reg_write, 0);
      chk("t4_ovf_hold", a_ovf, 1);
      a_ovf_clr = 1;
      step(1); a_ovf_clr = 0;
      chk("t4_ovf_clr", a_ovf, 0);
      step(2);

      // lock timeout with LOCK_MAX=8, queued A write drains after
      b_req = 1; b_we = 0; b_lock = 1; b_addr = 6'h08;
      step(2);
      chk("t5_b_rdata", b_rdata, 8'h31);
      b_req = 0; b_lock = 0;
      step(1);
      a_write = 1; a_addr = 6'h3F; a_wdata = 8'hFF;
      step(1); a_write = 0;
      step(4);
      chk("t5_lock_to_early", lock_to, 0);
      step(1);
      chk("t5_lock_to", lock_to, 1);
      step(1);
      chk("t5_drain_write", reg_write, 1);
      chk("t5_drain_addr", reg_addr, 6'h3F);
      chk("t5_lock_to_pulse", lock_to, 0);
      b_req = 1; b_we = 1; b_lock = 0; b_addr = 6'h09; b_wdata = 8'h42;
      step(2);
      chk("t5_b_ack", b_ack, 1);
      b_req = 0;
      a_read = 1; a_addr = 6'h0A;
      step(1); a_read = 0;
      chk("t5_unlocked_read", reg_read, 1);
      chk("t5_unlocked_addr", reg_addr, 6'h0A);
      step(2);

      // reset with two queued A reads
      b_req = 1; b_we = 1; b_lock = 1; b_addr = 6'h01; b_wdata = 8'h99;
      step(1);
      a_read = 1; a_addr = 6'h04;
      step(1);
      a_addr = 6'h05; b_req = 0; b_lock = 0;
      step(1);
      a_read = 0; rst = 1;
      step(1);
      rst = 0;
      chk_all_zero("t6");
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("t6_no_read", reg_read, 0);
         chk("t6_no_write", reg_write, 0);
         chk("t6_no_rvalid", a_rvalid, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reg_bus_arb.md
# reg_bus_arb

Arbiter and sequencer for the PWM peripheral's internal 6-bit-address / 8-bit-data register bus. It shares the bus between two requesters. Port A is the SPI instruction-decoder path: single-cycle read/write pulses that cannot be stalled. Port B is an internal requester with a req/ack handshake and an optional bus lock for atomic multi-byte updates. Port A accesses that arrive while B holds the lock are queued in a small FIFO, then drained in order.

## Interface
- FIFO_DEPTH, 2: entries in the port-A hold FIFO (≥1).
- LOCK_MAX, 64: max cycles B may hold the lock before forced release (≥2).

- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- a_read, a_write  in  1  port-A single-cycle pulses; never both high.
- a_addr  in  6  port-A address, valid with pulse.
- a_wdata  in  8  port-A write data, valid with a_write.
- a_rdata  out  8  port-A read data, valid while a_rvalid=1.
- a_rvalid  out  1  one-cycle pulse, port-A read completed.
- a_ovf  out  1  sticky: a port-A access was dropped (FIFO full).
- a_ovf_clr  in  1  clears a_ovf.
- b_req  in  1  port-B request; held high until b_ack.
- b_we  in  1  1=write, 0=read; stable with b_req.
- b_lock  in  1  request/keep the bus lock after this access.
- b_addr  in  6  port-B address.
- b_wdata  in  8  port-B write data.
- b_rdata  out  8  port-B read data, valid while b_ack=1.
- b_ack  out  1  one-cycle pulse, port-B access completed.
- lock_to  out  1  one-cycle pulse, lock forcibly released.
- reg_read, reg_write  out  1  bus strobes, one cycle each, registered.
- reg_addr  out  6  bus address, registered.
- reg_wdata  out  8  bus write data, registered.
- reg_rdata  in  8  register data for reg_addr; combinational, valid in the strobe cycle.

## Operation
- The bus carries at most one access per cycle. Each access is a one-cycle reg_read or reg_write with reg_addr/reg_wdata.
- State IDLE: the FIFO is empty and there is no lock.
  - A pulse in cycle N is issued on the bus in N+1.
  - If b_req is pending and there is no A pulse, B is issued.
  - If A and B are simultaneous, A wins and B waits.
- State LOCKED: entered when a B access is issued with b_lock=1.
  - Only B accesses are issued.
  - A pulses are pushed into the FIFO.
  - Exit happens when a B access is issued with b_lock=0, or on timeout.
  - On exit, go to DRAIN if the FIFO is non-empty, else IDLE.
- State DRAIN: pops and issues one FIFO entry per cycle.
  - New A pulses are pushed, preserving order, so A never bypasses the FIFO.
  - B waits.
  - Go to IDLE when the FIFO is empty after the final issue.
- B handshake: b_req is sampled only when B has no access in flight. After B is accepted, b_req is ignored until the cycle after b_ack, so back-to-back B accesses occur at most one per 3 cycles.
- Timeout: a counter clears on LOCKED entry and increments each LOCKED cycle. When it reaches LOCK_MAX:
  - Pulse lock_to.
  - Leave LOCKED.
  - An already-accepted B access still completes and acks.
  - Later B requests need b_lock again.
- Overflow: an A pulse arriving with the FIFO full is dropped and a_ovf is set.
  - a_ovf_clr clears a_ovf.
  - If set and clear occur in the same cycle, set wins.
  - A push and pop in the same cycle with the FIFO full is a legal push, not an overflow.
- Write data is forwarded unmodified. No arithmetic is done on data. Addresses cover the full range 0–63, with no decoding.

## Timing
- Reset values: every output 0 (a_rdata, b_rdata, reg_addr, reg_wdata = 0; all strobes, pulses and a_ovf = 0). FSM goes to IDLE, FIFO empty, lock counter 0.
- Unqueued A read: pulse at N, reg_read at N+1, a_rdata/a_rvalid at N+2.
- A write: reg_write at N+1. There is no port-A write acknowledge.
- B access: accepted at N, strobe at N+1, b_ack (and b_rdata for reads) at N+2.
- Queued A access: strobe in the cycle it pops. a_rvalid follows one cycle later.
- rdata registers hold their value until the next read completion on the same port.
- When rst is asserted mid-operation, the FIFO contents and any in-flight access are discarded. No ack or rvalid is issued after reset.

## Test plan
- Single A read of addr 0x05, with reg_rdata=0x3C during the strobe: reg_read at N+1, a_rvalid with a_rdata=0x3C at N+2.
- A write (0x12, 0xA5) and B read (0x07) in the same cycle: A strobe at N+1, B strobe at N+2, b_ack at N+3.
- B locked write 0x10, then unlocked write 0x11; an A read of 0x02 arrives between them: bus order is 0x10, 0x11, then 0x02; a_rvalid follows the 0x02 strobe by 1 cycle.
- Three A writes during a lock with FIFO_DEPTH=2: the first two are issued in order after unlock, the third is dropped, and a_ovf=1 until a_ovf_clr.
- B holds b_lock=1 with LOCK_MAX=8 and issues no unlock access: lock_to pulses after 8 LOCKED cycles, and queued A entries drain next.
- rst asserted with 2 FIFO entries queued: all outputs are 0 next cycle, no strobes occur, and a_rvalid stays 0.
